arb_mux_nto1: RTL and testbench

ARB_MUX_NTO1 -- requirements
Module: arb_mux_nto1

---
 rtl/arb_mux_nto1.sv | 93 +++++++++
 tb/tb_arb_mux_nto1.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/arb_mux_nto1.sv
// N-to-1 arbitrated multiplexer with a registered output stage.
// Selects one requesting channel per cycle, by fixed priority or round-robin, and holds it under downstream backpressure.
module arb_mux_nto1 #(
   parameter int SIZE  = 32,
   parameter int NUM   = 3,
   parameter int SEL_W = 2,
   parameter int MODE  = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NUM-1:0]        req_i,
   input  logic [NUM*SIZE-1:0]   data_i,
   output logic [NUM-1:0]        gnt_o,
   output logic [SIZE-1:0]       data_o,
   output logic [SEL_W-1:0]      sel_o,
   output logic                  valid_o,
   input  logic                  ready_i
);

   logic [SIZE-1:0]  r_data;
   logic [SEL_W-1:0] r_sel;
   logic             r_valid;
   logic [SEL_W-1:0] r_ptr;

   logic             w_load;
   logic             w_grant;
   logic             w_found;
   logic [SEL_W-1:0] w_idx;
   logic [SIZE-1:0]  w_data;
   logic [NUM-1:0]   w_gnt;
   logic [SEL_W-1:0] w_ptr_next;

   // The output register can take a new word when it is empty or being drained this cycle.
   assign w_load  = !r_valid || ready_i;
   assign w_grant = w_load && (req_i != '0) && !rst_i;

   // Search NUM channels starting at the pointer (round-robin) or at channel 0 (fixed priority).
   always_comb begin
      int v_start;
      int v_c;
      // NOTE: every variable gets a default before the search loop, otherwise a latch is inferred.
      w_found = 1'b0;
      w_idx   = '0;
      v_start = (MODE == 1) ? int'(r_ptr) : 0;
      for (int i = 0; i < NUM; i++) begin
         v_c = v_start + i;
         if (v_c >= NUM) v_c = v_c - NUM;
         if (!w_found && req_i[SEL_W'(v_c)]) begin
            w_found = 1'b1;
            w_idx   = SEL_W'(v_c);
         end
      end
   end

   always_comb begin
      w_data = '0;
      for (int k = 0; k < NUM; k++) begin
         if (SEL_W'(k) == w_idx) w_data = data_i[k*SIZE +: SIZE];
      end
   end

   always_comb begin
      w_gnt = '0;
      if (w_grant) w_gnt[w_idx] = 1'b1;
   end

   assign w_ptr_next = (w_idx == SEL_W'(NUM - 1)) ? '0 : w_idx + 1'b1;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_data  <= '0;
         r_sel   <= '0;
         r_valid <= 1'b0;
         r_ptr   <= '0;
      end else if (w_load) begin
         if (w_grant) begin
            r_data  <= w_data;
            r_sel   <= w_idx;
            r_valid <= 1'b1;
            if (MODE == 1) r_ptr <= w_ptr_next;
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   assign gnt_o   = w_gnt;
   assign data_o  = r_data;
   assign sel_o   = r_sel;
   assign valid_o = r_valid;

endmodule

// File: tb/tb_arb_mux_nto1.sv
// Directed bench for arb_mux_nto1: one round-robin and one fixed-priority instance share all inputs.
module tb_arb_mux_nto1;

   localparam int SIZE  = 32;
   localparam int NUM   = 3;
   localparam int SEL_W = 2;

   logic                clk_i = 1'b0;
   logic                rst_i;
   logic [NUM-1:0]      req_i;
   logic [NUM*SIZE-1:0] data_i;
   logic                ready_i;

   logic [NUM-1:0]   rr_gnt,   fp_gnt;
   logic [SIZE-1:0]  rr_data,  fp_data;
   logic [SEL_W-1:0] rr_sel,   fp_sel;
   logic             rr_valid, fp_valid;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   arb_mux_nto1 #(.SIZE(SIZE), .NUM(NUM), .SEL_W(SEL_W), .MODE(1)) u_rr (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .data_i(data_i),
      .gnt_o(rr_gnt), .data_o(rr_data), .sel_o(rr_sel), .valid_o(rr_valid), .ready_i(ready_i)
   );

   arb_mux_nto1 #(.SIZE(SIZE), .NUM(NUM), .SEL_W(SEL_W), .MODE(0)) u_fp (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .data_i(data_i),
      .gnt_o(fp_gnt), .data_o(fp_data), .sel_o(fp_sel), .valid_o(fp_valid), .ready_i(ready_i)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_data(input logic [SIZE-1:0] d0, input logic [SIZE-1:0] d1, input logic [SIZE-1:0] d2);
      data_i = {d2, d1, d0};
   endtask

   initial begin
      // Reset with all requests high: grants stay low, outputs clear.
      rst_i = 1'b1; req_i = 3'b111; ready_i = 1'b1;
      set_data(32'hA0, 32'h11, 32'h22);
      #1;
      check("rst_rr_gnt", rr_gnt, 3'b000);
      check("rst_fp_gnt", fp_gnt, 3'b000);
      tick();
      check("rst_rr_valid", rr_valid, 1'b0);
      check("rst_rr_data",  rr_data,  32'h0);
      check("rst_rr_sel",   rr_sel,   2'd0);
      check("rst_fp_valid", fp_valid, 1'b0);

      // Round-robin rotation with all channels requesting: 0,1,2,0.
      rst_i = 1'b0;
      #1;
      check("rr_first_gnt", rr_gnt, 3'b001);
      check("fp_first_gnt", fp_gnt, 3'b001);
      tick();
      check("rr_seq0_sel",   rr_sel,   2'd0);
      check("rr_seq0_valid", rr_valid, 1'b1);
      check("rr_seq0_data",  rr_data,  32'hA0);
      check("rr_seq0_gnt",   rr_gnt,   3'b010);
      tick();
      check("rr_seq1_sel",   rr_sel,   2'd1);
      check("rr_seq1_data",  rr_data,  32'h11);
      check("rr_seq1_valid", rr_valid, 1'b1);
      tick();
      check("rr_seq2_sel",   rr_sel,   2'd2);
      check("rr_seq2_data",  rr_data,  32'h22);
      check("fp_seq2_sel",   fp_sel,   2'd0);
      tick();
      check("rr_seq3_sel",   rr_sel,   2'd0);
      check("rr_seq3_valid", rr_valid, 1'b1);

      // Drain with no requests: valid drops, word retained.
      req_i = 3'b000;
      #1;
      check("idle_rr_gnt", rr_gnt, 3'b000);
      tick();
      check("idle_rr_valid", rr_valid, 1'b0);
      check("idle_rr_data",  rr_data,  32'hA0);
      check("idle_rr_sel",   rr_sel,   2'd0);
      check("idle_fp_data",  fp_data,  32'hA0);

      // Fixed priority picks ch1 from 3'b110; round-robin pointer is at 1 as well.
      req_i = 3'b110;
      #1;
      check("fp_110_gnt", fp_gnt, 3'b010);
      check("rr_110_gnt", rr_gnt, 3'b010);
      tick();
      check("fp_110_data", fp_data, 32'h11);
      check("fp_110_sel",  fp_sel,  2'd1);

      // Pointer now 2, requests 3'b011: search wraps to ch0.
      req_i = 3'b011;
      #1;
      check("rr_wrap_gnt", rr_gnt, 3'b001);
      tick();
      check("rr_wrap_sel",  rr_sel,  2'd0);
      check("rr_wrap_data", rr_data, 32'hA0);

      // Stall four cycles with ch0 presenting a new word.
      ready_i = 1'b0; req_i = 3'b001;
      set_data(32'h5A, 32'h11, 32'h22);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("stall_rr_gnt", rr_gnt, 3'b000);
         check("stall_fp_gnt", fp_gnt, 3'b000);
         tick();
         check("stall_rr_data",  rr_data,  32'hA0);
         check("stall_rr_sel",   rr_sel,   2'd0);
         check("stall_rr_valid", rr_valid, 1'b1);
      end
      ready_i = 1'b1;
      #1;
      check("unstall_rr_gnt", rr_gnt, 3'b001);
      tick();
      check("unstall_rr_data", rr_data, 32'h5A);
      check("unstall_fp_data", fp_data, 32'h5A);
      check("unstall_rr_valid", rr_valid, 1'b1);

      // Pointer is 1 after the ch0 grant: 3'b011 gives ch1 (RR) vs ch0 (FP), back-to-back.
      req_i = 3'b011;
      #1;
      check("rr_ptr1_gnt", rr_gnt, 3'b010);
      check("fp_011_gnt",  fp_gnt, 3'b001);
      tick();
      check("rr_ptr1_sel",  rr_sel,  2'd1);
      check("rr_ptr1_data", rr_data, 32'h11);
      check("fp_011_sel",   fp_sel,  2'd0);

      // Reset during a stall discards the held word; next search starts at ch0 (pointer was 2).
      ready_i = 1'b0; req_i = 3'b111;
      tick();
      check("pre_rst_rr_valid", rr_valid, 1'b1);
      check("pre_rst_rr_data",  rr_data,  32'h11);
      rst_i = 1'b1;
      #1;
      check("rst_stall_gnt", rr_gnt, 3'b000);
      tick();
      check("rst_stall_valid", rr_valid, 1'b0);
      check("rst_stall_data",  rr_data,  32'h0);
      check("rst_stall_sel",   rr_sel,   2'd0);
      rst_i = 1'b0; ready_i = 1'b1;
      #1;
      check("post_rst_gnt", rr_gnt, 3'b001);
      tick();
      check("post_rst_sel",  rr_sel,  2'd0);
      check("post_rst_data", rr_data, 32'h5A);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
